// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: run/pause/stop control of four LED patterns,
// advanced by a programmable tick divider.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | LEDs dark, counter cleared, mode button selects the pattern
// S_RUN   | counter runs, LEDs advance one frame per period
// S_PAUSE | counter and LEDs frozen, run resumes from the held count
module led_pattern_sequencer #(
  parameter int N_LED      = 8,
  parameter int BASE_TICKS = 12500000,
  parameter int CNT_W      = $clog2(BASE_TICKS * 8)
) (
  input  logic             clk,
  input  logic             rst,        // active-low despite the name
  input  logic             btn_run,
  input  logic             btn_stop,
  input  logic             btn_mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] leds,
  output logic             running,
  output logic             tick
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_CHASE_L = 2'd0,
    PAT_CHASE_R = 2'd1,
    PAT_BOUNCE  = 2'd2,
    PAT_BLINK   = 2'd3
  } pattern_e;

  localparam logic [N_LED-1:0] FRAME_LSB = N_LED'(1);
  localparam logic [N_LED-1:0] FRAME_MSB = FRAME_LSB << (N_LED - 1);
  localparam logic [N_LED-1:0] FRAME_ALL = '1;

  // One bit wider than the counter so BASE_TICKS << 3 is representable
  // before the -1; the counter itself only ever reaches that value minus 1.
  localparam logic [CNT_W:0] BASE_EXT = (CNT_W + 1)'(BASE_TICKS);

  // Button bit order in the front-end vectors: {mode, stop, run}.
  localparam int B_RUN  = 0;
  localparam int B_STOP = 1;
  localparam int B_MODE = 2;

  logic [2:0] btn_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] sync3_q;
  logic [2:0] pulse_q;
  logic [2:0] pulse_d;

  state_e             state_q,    state_d;
  pattern_e           pattern_q,  pattern_d;
  logic [N_LED-1:0]   leds_q,     leds_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [1:0]         speed_r_q,  speed_r_d;
  logic               dir_left_q, dir_left_d;
  logic               tick_q,     tick_d;
  logic               running_q,  running_d;

  logic               run_p;
  logic               stop_p;
  logic               mode_p;
  pattern_e           pattern_nxt;
  logic [CNT_W:0]     last_cnt;
  logic               at_last;
  logic [N_LED-1:0]   adv_frame;
  logic               adv_dir_left;

  function automatic logic [N_LED-1:0] init_frame(input pattern_e p);
    logic [N_LED-1:0] f;
    case (p)
      PAT_CHASE_L: f = FRAME_LSB;
      PAT_CHASE_R: f = FRAME_MSB;
      PAT_BOUNCE:  f = FRAME_LSB;
      PAT_BLINK:   f = FRAME_ALL;
      default:     f = FRAME_LSB;
    endcase
    return f;
  endfunction

  assign btn_raw = {btn_mode, btn_stop, btn_run};

  // Buttons are pre-debounced; the third stage only serves edge detection.
  assign pulse_d = sync2_q & ~sync3_q;

  // Two-flop synchronizer, edge-detect history and registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pulse_q <= pulse_d;
    end
  end

  // Stop outranks run, run outranks mode; lower-priority pulses are dropped.
  assign stop_p = pulse_q[B_STOP];
  assign run_p  = pulse_q[B_RUN]  & ~pulse_q[B_STOP];
  assign mode_p = pulse_q[B_MODE] & ~pulse_q[B_STOP] & ~pulse_q[B_RUN];

  assign pattern_nxt = pattern_e'(pattern_q + 2'd1);

  // Period end compare uses the speed latched at the start of the period.
  assign last_cnt = (BASE_EXT << speed_r_q) - (CNT_W + 1)'(1);
  assign at_last  = ({1'b0, cnt_q} == last_cnt);

  // Next frame and bounce direction for the current pattern.
  always_comb begin
    adv_frame    = leds_q;
    adv_dir_left = dir_left_q;
    case (pattern_q)
      PAT_CHASE_L: adv_frame = {leds_q[N_LED-2:0], leds_q[N_LED-1]};
      PAT_CHASE_R: adv_frame = {leds_q[0], leds_q[N_LED-1:1]};
      PAT_BOUNCE: begin
        // Reverse when the lit bit sits at an end, so end frames show once.
        if (dir_left_q) begin
          if (leds_q[N_LED-1]) begin
            adv_frame    = leds_q >> 1;
            adv_dir_left = 1'b0;
          end else begin
            adv_frame    = leds_q << 1;
          end
        end else begin
          if (leds_q[0]) begin
            adv_frame    = leds_q << 1;
            adv_dir_left = 1'b1;
          end else begin
            adv_frame    = leds_q >> 1;
          end
        end
      end
      PAT_BLINK:   adv_frame = ~leds_q;
      default:     adv_frame = leds_q;
    endcase
  end

  // Sequencer next-state, frame, counter and output decode.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    leds_d     = leds_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    tick_d     = 1'b0;
    speed_r_d  = (cnt_q == '0) ? speed : speed_r_q;

    unique case (state_q)
      S_IDLE: begin
        leds_d     = '0;
        cnt_d      = '0;
        dir_left_d = 1'b1;
        if (run_p) begin
          state_d = S_RUN;
          leds_d  = init_frame(pattern_q);
        end else if (mode_p) begin
          pattern_d = pattern_nxt;
        end
      end

      S_RUN: begin
        if (stop_p) begin
          state_d    = S_IDLE;
          leds_d     = '0;
          cnt_d      = '0;
          dir_left_d = 1'b1;
        end else if (run_p) begin
          state_d = S_PAUSE;
        end else if (mode_p) begin
          pattern_d  = pattern_nxt;
          leds_d     = init_frame(pattern_nxt);
          cnt_d      = '0;
          dir_left_d = 1'b1;
        end else if (at_last) begin
          cnt_d      = '0;
          tick_d     = 1'b1;
          leds_d     = adv_frame;
          dir_left_d = adv_dir_left;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PAUSE: begin
        if (stop_p) begin
          state_d    = S_IDLE;
          leds_d     = '0;
          cnt_d      = '0;
          dir_left_d = 1'b1;
        end else if (run_p) begin
          state_d = S_RUN;
        end else if (mode_p) begin
          pattern_d  = pattern_nxt;
          leds_d     = init_frame(pattern_nxt);
          cnt_d      = '0;
          dir_left_d = 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        leds_d     = '0;
        cnt_d      = '0;
        dir_left_d = 1'b1;
      end
    endcase

    running_d = (state_d == S_RUN);
  end

  // Sequencer state register; every output is driven straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pattern_q  <= PAT_CHASE_L;
      leds_q     <= '0;
      cnt_q      <= '0;
      speed_r_q  <= 2'd0;
      dir_left_q <= 1'b1;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      leds_q     <= leds_d;
      cnt_q      <= cnt_d;
      speed_r_q  <= speed_r_d;
      dir_left_q <= dir_left_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
    end
  end

  assign leds    = leds_q;
  assign running = running_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus random button
// traffic, all compared each cycle against a frame-index reference model.
module tb_led_pattern_sequencer;

  localparam int N_LED = 8;
  localparam int BASE  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_mode = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [N_LED-1:0] leds;
  logic       running;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .N_LED      (N_LED),
    .BASE_TICKS (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_stop (btn_stop),
    .btn_mode (btn_mode),
    .speed    (speed),
    .leds     (leds),
    .running  (running),
    .tick     (tick)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 pause; m_k counts frames since the pattern start
  int       m_st, m_pat, m_k, m_cnt, m_spd;
  bit       m_tick;
  bit [3:0] h_run, h_stop, h_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame(input int p, input int k);
    int pos;
    case (p)
      0: return 1 << (k % N_LED);
      1: return (1 << (N_LED - 1)) >> (k % N_LED);
      2: begin
        pos = k % (2 * N_LED - 2);
        return (pos < N_LED) ? (1 << pos) : (1 << (2 * N_LED - 2 - pos));
      end
      default: return (k % 2) ? 0 : (1 << N_LED) - 1;
    endcase
  endfunction

  task automatic m_reset();
    m_st = 0; m_pat = 0; m_k = 0; m_cnt = 0; m_spd = 0; m_tick = 0;
    h_run = '0; h_stop = '0; h_mode = '0;
  endtask

  // A press sampled at edge e acts at edge e+3 (rising edge seen 4 edges late).
  task automatic m_edge();
    bit a_run, a_stop, a_mode;
    int p_last, spd_next;
    if (!rst) begin
      m_reset();
      return;
    end
    a_stop = h_stop[2] & ~h_stop[3];
    a_run  = h_run[2]  & ~h_run[3];
    a_mode = h_mode[2] & ~h_mode[3];
    h_run  = {h_run[2:0],  btn_run};
    h_stop = {h_stop[2:0], btn_stop};
    h_mode = {h_mode[2:0], btn_mode};
    p_last   = (BASE << m_spd) - 1;
    spd_next = (m_cnt == 0) ? int'(speed) : m_spd;
    m_tick = 0;
    if (a_stop) begin
      if (m_st != 0) begin m_st = 0; m_cnt = 0; end
    end else if (a_run) begin
      if (m_st == 0) begin m_st = 1; m_k = 0; m_cnt = 0; end
      else if (m_st == 1) m_st = 2;
      else m_st = 1;
    end else if (a_mode) begin
      m_pat = (m_pat + 1) % 4;
      if (m_st != 0) begin m_k = 0; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (m_cnt == p_last) begin m_cnt = 0; m_tick = 1; m_k++; end
      else m_cnt++;
    end
    m_spd = spd_next;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    check("model_leds", 32'(leds), (m_st == 0) ? 32'd0 : 32'(frame(m_pat, m_k)));
    check("model_running", 32'(running), 32'(m_st == 1));
    check("model_tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 200);
    if (tick !== 1'b1) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic press(input int b);
    case (b)
      0: btn_run = 1'b1;
      1: btn_stop = 1'b1;
      default: btn_mode = 1'b1;
    endcase
    step(); step();
    btn_run = 1'b0; btn_stop = 1'b0; btn_mode = 1'b0;
    repeat (4) step();
  endtask

  logic [7:0] bounce_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
  logic [7:0] chase_exp [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                8'h40, 8'h80, 8'h01, 8'h02};

  initial begin
    int n;
    int guard;
    logic [7:0] held;
    m_reset();
    #1 rst = 1'b0;
    repeat (3) step();
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst = 1'b1;
    step(); step();

    // chase left from reset, frame visible on the 4th edge after the press
    btn_run = 1'b1;
    step(); step(); step();
    check("run_before_4th", 32'(running), 32'd0);
    step();
    btn_run = 1'b0;
    check("run_first_led", 32'(leds), 32'h01);
    check("run_running", 32'(running), 32'd1);
    for (int i = 0; i < 9; i++) begin
      wait_tick(n);
      check("chase_gap", 32'(n), 32'd4);
      check("chase_l", 32'(leds), 32'(chase_exp[i]));
    end

    // bounce, selected by two mode presses in idle
    press(1);
    check("stop_leds", 32'(leds), 32'd0);
    press(2);
    press(2);
    check("idle_mode_leds", 32'(leds), 32'd0);
    press(0);
    check("bounce_0", 32'(leds), 32'(bounce_exp[0]));
    for (int i = 1; i < 10; i++) begin
      wait_tick(n);
      check("bounce", 32'(leds), 32'(bounce_exp[i]));
    end

    // pause with the counter held at 2, then resume
    guard = 0;
    while (!(m_st == 1 && m_cnt == 3) && guard < 100) begin step(); guard++; end
    btn_run = 1'b1;
    step(); step();
    btn_run = 1'b0;
    step(); step();
    check("pause_running", 32'(running), 32'd0);
    held = leds;
    for (int i = 0; i < 20; i++) begin
      step();
      check("pause_leds", 32'(leds), 32'(held));
      check("pause_tick", 32'(tick), 32'd0);
    end
    btn_run = 1'b1;
    step(); step();
    btn_run = 1'b0;
    step(); step();
    check("resume_running", 32'(running), 32'd1);
    wait_tick(n);
    check("resume_gap", 32'(n), 32'd2);

    // coincident stop and run in RUN: stop wins
    btn_stop = 1'b1; btn_run = 1'b1;
    repeat (4) step();
    btn_stop = 1'b0; btn_run = 1'b0;
    check("stoprun_running", 32'(running), 32'd0);
    check("stoprun_leds", 32'(leds), 32'd0);
    repeat (4) step();
    check("stoprun_still_idle", 32'(running), 32'd0);

    // speed change mid-period
    press(0);
    wait_tick(n);
    step(); step();
    speed = 2'd3;
    wait_tick(n);
    check("speed_cur_period", 32'(n + 2), 32'd4);
    wait_tick(n);
    check("speed_new_period", 32'(n), 32'd32);
    wait_tick(n);
    check("speed_new_period2", 32'(n), 32'd32);
    speed = 2'd0;

    // blink, then asynchronous reset between edges
    press(2);
    check("blink_init", 32'(leds), 32'hFF);
    wait_tick(n);
    check("blink_inv", 32'(leds), 32'h00);
    wait_tick(n);
    check("blink_inv2", 32'(leds), 32'hFF);
    #2 rst = 1'b0;
    #1;
    check("arst_leds", 32'(leds), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    m_reset();
    step(); step();
    rst = 1'b1;
    step();
    btn_run = 1'b1;
    repeat (4) step();
    btn_run = 1'b0;
    check("post_rst_led", 32'(leds), 32'h01);
    check("post_rst_running", 32'(running), 32'd1);

    // random button and speed traffic
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) == 0)  btn_run  = ~btn_run;
      if ($urandom_range(0, 29) == 0) btn_stop = ~btn_stop;
      if ($urandom_range(0, 14) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
